// File: rtl/keypad_pkg.sv
// Scan codes, key classes and FSM states for the keypad number entry block.
// Numpad codes are only used when KEYPAD_NUMBER_ENTRY_NUMPAD_EN is defined.
package keypad_pkg;

    localparam logic [8:0] SC_DIGIT [10] = '{
        9'h045, 9'h016, 9'h01E, 9'h026, 9'h025,
        9'h02E, 9'h036, 9'h03D, 9'h03E, 9'h046
    };

    localparam logic [8:0] SC_NUMPAD [10] = '{
        9'h070, 9'h069, 9'h072, 9'h07A, 9'h06B,
        9'h073, 9'h074, 9'h06C, 9'h075, 9'h07D
    };

    localparam logic [8:0] SC_ENTER    = 9'h05A;
    localparam logic [8:0] SC_KP_ENTER = 9'h15A;
    localparam logic [8:0] SC_BKSP     = 9'h066;
    localparam logic [8:0] SC_ESC      = 9'h076;
    localparam logic [8:0] SC_KP_MINUS = 9'h07B;

    typedef enum logic [2:0] {
        KC_NONE,
        KC_DIGIT,
        KC_ENTER,
        KC_BKSP,
        KC_ESC
    } key_class_e;

    typedef enum logic {
        ST_IDLE,
        ST_HELD
    } state_e;

endpackage

// File: rtl/ps2_key_classifier.sv
// Maps a 9-bit scan code (bit 8 = E0 flag) to a key class and digit.
// Numpad digits and keypad '-' decode under KEYPAD_NUMBER_ENTRY_NUMPAD_EN.
module ps2_key_classifier
    import keypad_pkg::*;
(
    input  logic [8:0] code_i,
    output key_class_e kc_o,
    output logic [3:0] digit_o
);

    always_comb begin
        kc_o    = KC_NONE;
        digit_o = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (code_i == SC_DIGIT[i]) begin
                kc_o    = KC_DIGIT;
                digit_o = 4'(i);
            end
        end
`ifdef KEYPAD_NUMBER_ENTRY_NUMPAD_EN
        for (int i = 0; i < 10; i++) begin
            if (code_i == SC_NUMPAD[i]) begin
                kc_o    = KC_DIGIT;
                digit_o = 4'(i);
            end
        end
        if (code_i == SC_KP_MINUS) kc_o = KC_BKSP;
`endif
        case (code_i)
            SC_ENTER, SC_KP_ENTER: kc_o = KC_ENTER;
            SC_BKSP:               kc_o = KC_BKSP;
            SC_ESC:                kc_o = KC_ESC;
            default: ;
        endcase
    end

endmodule

// File: rtl/keypad_number_entry.sv
// Multi-digit decimal entry with backspace, clear and range-checked commit.
// Optional numpad decode: define KEYPAD_NUMBER_ENTRY_NUMPAD_EN.
module keypad_number_entry
    import keypad_pkg::*;
#(
    parameter int MAX_DIGITS = 2,
    parameter int VAL_W      = 7,
    parameter int MIN_VALUE  = 1,
    parameter int MAX_VALUE  = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    input  logic [8:0]       last_change,
    input  logic             key_is_down,
    output logic [VAL_W-1:0] entry_value,
    output logic [2:0]       digit_count,
    output logic             num_valid,
    output logic [VAL_W-1:0] num_value,
    output logic             err_pulse
);

    localparam int BUF_W = 4 * MAX_DIGITS;

    key_class_e       kc;
    logic [3:0]       digit;
    state_e           state_q, state_d;
    logic [8:0]       held_q, held_d;
    logic [BUF_W-1:0] digits_q, digits_d;
    logic [2:0]       count_q, count_d;
    logic [VAL_W-1:0] num_value_q, num_value_d;
    logic             num_valid_q, num_valid_d;
    logic             err_q, err_d;
    logic [31:0]      value;
    logic             act, rel_held, in_range;

    ps2_key_classifier u_cls (
        .code_i  (last_change),
        .kc_o    (kc),
        .digit_o (digit)
    );

    // Digit 0 of the buffer is the most recently typed (least significant)
    always_comb begin
        logic [31:0] pw;
        value = '0;
        pw    = 32'd1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            value = value + 32'(digits_q[4*i +: 4]) * pw;
            pw    = pw * 32'd10;
        end
    end

    assign in_range = (count_q != 3'd0)
                   && (value >= 32'(MIN_VALUE))
                   && (value <= 32'(MAX_VALUE));

    assign act = (state_q == ST_IDLE) && key_valid
              && key_is_down && (kc != KC_NONE);

    assign rel_held = (state_q == ST_HELD) && key_valid
                   && !key_is_down && (last_change == held_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            held_q      <= '0;
            digits_q    <= '0;
            count_q     <= '0;
            num_value_q <= '0;
            num_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            held_q      <= held_d;
            digits_q    <= digits_d;
            count_q     <= count_d;
            num_value_q <= num_value_d;
            num_valid_q <= num_valid_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (act)      state_d = ST_HELD;
            ST_HELD: if (rel_held) state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        held_d      = held_q;
        digits_d    = digits_q;
        count_d     = count_q;
        num_value_d = num_value_q;
        num_valid_d = 1'b0;
        err_d       = 1'b0;
        if (act) begin
            held_d = last_change;
            case (kc)
                KC_DIGIT: begin
                    if (count_q < 3'(MAX_DIGITS)) begin
                        digits_d = (digits_q << 4) | BUF_W'(digit);
                        count_d  = count_q + 3'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                KC_BKSP: begin
                    if (count_q != 3'd0) begin
                        digits_d = digits_q >> 4;
                        count_d  = count_q - 3'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                KC_ESC: begin
                    digits_d = '0;
                    count_d  = '0;
                end
                KC_ENTER: begin
                    if (in_range) begin
                        num_value_d = value[VAL_W-1:0];
                        num_valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    digits_d = '0;
                    count_d  = '0;
                end
                default: ;
            endcase
        end
    end

    assign entry_value = value[VAL_W-1:0];
    assign digit_count = count_q;
    assign num_valid   = num_valid_q;
    assign num_value   = num_value_q;
    assign err_pulse   = err_q;

endmodule

// File: tb/tb_keypad_number_entry.sv
// Scoreboard bench for keypad_number_entry with default parameters.
// Numpad checks follow KEYPAD_NUMBER_ENTRY_NUMPAD_EN.
module tb_keypad_number_entry;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [8:0] last_change = '0;
    logic       key_is_down = 1'b0;
    logic [6:0] entry_value;
    logic [2:0] digit_count;
    logic       num_valid;
    logic [6:0] num_value;
    logic       err_pulse;

    always #5 clk = ~clk;

    keypad_number_entry dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .last_change (last_change),
        .key_is_down (key_is_down),
        .entry_value (entry_value),
        .digit_count (digit_count),
        .num_valid   (num_valid),
        .num_value   (num_value),
        .err_pulse   (err_pulse)
    );

    typedef struct {
        int ent;
        int cnt;
        int nv;
        int nval;
        int er;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;

    logic [8:0] dig_tab [10] = '{
        9'h045, 9'h016, 9'h01E, 9'h026, 9'h025,
        9'h02E, 9'h036, 9'h03D, 9'h03E, 9'h046
    };
    logic [8:0] np_tab [10] = '{
        9'h070, 9'h069, 9'h072, 9'h07A, 9'h06B,
        9'h073, 9'h074, 9'h06C, 9'h075, 9'h07D
    };

    int         m_val = 0;
    int         m_cnt = 0;
    int         m_nval = 0;
    bit         m_hold = 0;
    logic [8:0] m_code = '0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    // kind: 0 none, 1 digit, 2 enter, 3 backspace, 4 escape
    function automatic void classify(input logic [8:0] c,
                                     output int k, output int d);
        k = 0;
        d = 0;
        for (int i = 0; i < 10; i++)
            if (c == dig_tab[i]) begin k = 1; d = i; end
`ifdef KEYPAD_NUMBER_ENTRY_NUMPAD_EN
        for (int i = 0; i < 10; i++)
            if (c == np_tab[i]) begin k = 1; d = i; end
        if (c == 9'h07B) k = 3;
`endif
        if (c == 9'h05A || c == 9'h15A) k = 2;
        if (c == 9'h066) k = 3;
        if (c == 9'h076) k = 4;
    endfunction

    task automatic step(input bit v, input logic [8:0] c, input bit dn);
        int   k, d, nv, er;
        exp_t e;
        @(negedge clk);
        rst = 1'b0;
        key_valid = v;
        last_change = c;
        key_is_down = dn;
        nv = 0;
        er = 0;
        classify(c, k, d);
        if (v && !m_hold && dn && k != 0) begin
            m_hold = 1;
            m_code = c;
            case (k)
                1: if (m_cnt < 2) begin
                       m_val = m_val * 10 + d;
                       m_cnt++;
                   end else er = 1;
                2: begin
                       if (m_cnt > 0 && m_val >= 1 && m_val <= 25) begin
                           m_nval = m_val;
                           nv = 1;
                       end else er = 1;
                       m_val = 0;
                       m_cnt = 0;
                   end
                3: if (m_cnt > 0) begin
                       m_val = m_val / 10;
                       m_cnt--;
                   end else er = 1;
                default: begin
                       m_val = 0;
                       m_cnt = 0;
                   end
            endcase
        end else if (v && m_hold && !dn && c == m_code) begin
            m_hold = 0;
        end
        e = '{m_val, m_cnt, nv, m_nval, er};
        sb.push_back(e);
    endtask

    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        rst = 1'b1;
        key_valid = 1'b0;
        m_val = 0;
        m_cnt = 0;
        m_nval = 0;
        m_hold = 0;
        m_code = '0;
        e = '{0, 0, 0, 0, 0};
        sb.push_back(e);
    endtask

    task automatic make(input logic [8:0] c);
        step(1, c, 1);
        step(0, c, 0);
    endtask

    task automatic brk(input logic [8:0] c);
        step(1, c, 0);
        step(0, c, 0);
    endtask

    task automatic press(input logic [8:0] c);
        make(c);
        brk(c);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("entry_value", 32'(entry_value), mon_e.ent);
            chk("digit_count", 32'(digit_count), mon_e.cnt);
            chk("num_valid", 32'(num_valid), mon_e.nv);
            chk("num_value", 32'(num_value), mon_e.nval);
            chk("err_pulse", 32'(err_pulse), mon_e.er);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        do_reset();
        do_reset();
        press(9'h016);
        press(9'h03D);
        press(9'h05A);
        press(9'h026);
        press(9'h045);
        press(9'h05A);
        press(9'h01E);
        press(9'h02E);
        press(9'h046);
        press(9'h066);
        press(9'h066);
        press(9'h066);
        for (int i = 0; i < 6; i++) make(9'h025);
        make(9'h02E);
        brk(9'h025);
        press(9'h02E);
        press(9'h076);
        press(9'h045);
        press(9'h03D);
        press(9'h066);
        press(9'h05A);
        press(9'h045);
        press(9'h05A);
        press(9'h145);
        press(9'h05A);
        make(9'h016);
        do_reset();
        brk(9'h016);
        press(9'h01E);
        press(9'h076);
        press(9'h06B);
        press(9'h069);
        press(9'h15A);
        press(9'h07B);
        repeat (3) @(negedge clk);
        chk("drain", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
